axi_ram_responder: RTL
======================

AXI_RAM_RESPONDER -- requirements
Module: axi_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits of internal RAM (depth 2^ADDR_WIDTH words).
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 6, width of all ID ports.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32, width of awaddr/araddr.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 64, RAM word and data-bus width, power of two >= 8.
REQ-005 SHALL have port aclk  in  1  sole clock; one clock; all logic on its rising edge.
REQ-006 SHALL have port areset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port s_axi_awid  in  AXI_ID_WIDTH  write burst ID.
REQ-008 SHALL have port s_axi_awlen  in  4  beats minus one (AXI3).
REQ-009 SHALL have port s_axi_awaddr  in  AXI_ADDR_WIDTH  byte start address.
REQ-010 SHALL have port s_axi_awvalid  in  1  AW valid.
REQ-011 SHALL have port s_axi_awready  out  1  AW ready.
REQ-012 SHALL have port s_axi_wdata  in  AXI_DATA_WIDTH  write data.
REQ-013 SHALL have port s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables (present only with macro, REQ-040).
REQ-014 SHALL have port s_axi_wlast  in  1  last write beat, informational.
REQ-015 SHALL have port s_axi_wvalid  in  1  W valid.
REQ-016 SHALL have port s_axi_wready  out  1  W ready.
REQ-017 SHALL have port s_axi_bid  out  AXI_ID_WIDTH  echoed awid.
REQ-018 SHALL have port s_axi_bvalid  out  1  write response valid (response always OKAY, not ported).
REQ-019 SHALL have port s_axi_bready  in  1  response ready.
REQ-020 SHALL have port s_axi_arid  in  AXI_ID_WIDTH  read burst ID.
REQ-021 SHALL have port s_axi_arlen  in  4  beats minus one.
REQ-022 SHALL have port s_axi_araddr  in  AXI_ADDR_WIDTH  byte start address.
REQ-023 SHALL have port s_axi_arvalid  in  1  AR valid.
REQ-024 SHALL have port s_axi_arready  out  1  AR ready.
REQ-025 SHALL have port s_axi_rid  out  AXI_ID_WIDTH  echoed arid.
REQ-026 SHALL have port s_axi_rdata  out  AXI_DATA_WIDTH  read data.
REQ-027 SHALL have port s_axi_rlast  out  1  last read beat.
REQ-028 SHALL have port s_axi_rvalid  out  1  R valid.
REQ-029 SHALL have port s_axi_rready  in  1  R ready.

Function
REQ-030 SHALL accept only full-width INCR bursts; size/burst/cache/wid not ported; word index = addr[ADDR_WIDTH+B-1:B], B=log2(AXI_DATA_WIDTH/8), incremented per beat modulo 2^ADDR_WIDTH (wrap to word 0).
REQ-031 SHALL run write FSM W_IDLE (awready=1) -> W_DATA on AW handshake (latch awid, address, awlen) -> W_RESP after awlen+1 W handshakes -> W_IDLE on B handshake.
REQ-032 SHALL assert wready only in W_DATA, starting the cycle after AW handshake; each W handshake writes one word; beat count from awlen only, wlast ignored.
REQ-033 SHALL assert bvalid, bid=latched awid, the cycle after the final W handshake and hold both until bready.
REQ-034 SHALL run read FSM R_IDLE (arready=1) -> R_DATA on AR handshake -> R_IDLE on handshake of beat with rlast.
REQ-035 SHALL present first rvalid one cycle after AR handshake, with rdata of start word, rid=arid, rlast=1 only on beat arlen.
REQ-036 SHALL hold rdata/rlast/rid stable while rvalid=1 and rready=0; with rready held high deliver one beat per cycle.
REQ-037 SHALL operate read and write channels independently and concurrently; same-word write and read in one cycle returns old data.

Reset
REQ-038 SHALL on areset immediately force both FSMs idle and awready, wready, bvalid, arready, rvalid, rlast to 0, bid/rid/rdata to 0; awready/arready go 1 first clock after release; an in-flight burst is abandoned without response; RAM contents not reset.

Configuration
REQ-039 SHALL use macro AXI_RAM_RESPONDER_WSTRB_EN.
REQ-040 SHALL with macro defined include s_axi_wstrb and write only bytes whose strobe bit is 1; without it omit the port and write all bytes every beat.

Verification
REQ-041 SHALL cover: awid=5, awaddr=0x100, awlen=3, wdata 1,2,3,4 -> bvalid, bid=5 one cycle after beat 4; read same -> rdata 1,2,3,4, rlast on beat 4 only.
REQ-042 SHALL cover: read awlen=7 with rready toggled every cycle -> 8 beats, no loss/duplication, rdata stable while stalled.
REQ-043 SHALL cover: ADDR_WIDTH=4, 64-bit, write awaddr=0x70 awlen=3 -> words 14,15,0,1 written; word 2 unchanged.
REQ-044 SHALL cover (macro defined): word 0xFFFFFFFFFFFFFFFF, rewrite 0 with wstrb=0x0F -> read 0xFFFFFFFF00000000.
REQ-045 SHALL cover: areset pulsed after 2 of 4 W beats -> bvalid never asserted, awready=1 first clock after release, new burst completes normally.

Source files
------------

// File: rtl/axi_ram_responder.sv
// axi_ram_responder: AXI3 INCR-burst slave backed by a word RAM with independent read and write channels.
// Define AXI_RAM_RESPONDER_WSTRB_EN to add s_axi_wstrb byte-enable writes; without it every beat writes the whole word.
module axi_ram_responder #(
    parameter int ADDR_WIDTH     = 10,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [3:0]                  s_axi_awlen,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
`ifdef AXI_RAM_RESPONDER_WSTRB_EN
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
`endif
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [3:0]                  s_axi_arlen,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);
    localparam int B = $clog2(AXI_DATA_WIDTH / 8);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic                      live;
    w_state_t                  w_state, w_next;
    r_state_t                  r_state, r_next;
    logic [ADDR_WIDTH-1:0]     w_addr, r_addr, aw_idx, ar_idx;
    logic [3:0]                w_left, r_left;
    logic                      aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic                      unused_bits;

    assign aw_idx  = s_axi_awaddr[ADDR_WIDTH+B-1:B];
    assign ar_idx  = s_axi_araddr[ADDR_WIDTH+B-1:B];
    assign aw_fire = s_axi_awvalid & s_axi_awready;
    assign w_fire  = s_axi_wvalid & s_axi_wready;
    assign b_fire  = s_axi_bvalid & s_axi_bready;
    assign ar_fire = s_axi_arvalid & s_axi_arready;
    assign r_fire  = s_axi_rvalid & s_axi_rready;
    assign unused_bits = ^{s_axi_wlast, s_axi_awaddr, s_axi_araddr};

    // Holds the address channels off until the first clock after reset release
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) live <= 1'b0;
        else        live <= 1'b1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        if (w_state == W_IDLE && aw_fire)                      w_next = W_DATA;
        else if (w_state == W_DATA && w_fire && w_left == 4'd0) w_next = W_RESP;
        else if (w_state == W_RESP && b_fire)                  w_next = W_IDLE;
    end

    always_comb begin
        s_axi_awready = live && w_state == W_IDLE;
        s_axi_wready  = w_state == W_DATA;
        s_axi_bvalid  = w_state == W_RESP;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_addr    <= '0;
            w_left    <= '0;
            s_axi_bid <= '0;
        end else if (aw_fire) begin
            w_addr    <= aw_idx;
            w_left    <= s_axi_awlen;
            s_axi_bid <= s_axi_awid;
        end else if (w_fire) begin
            w_addr <= w_addr + ADDR_WIDTH'(1);
            w_left <= w_left - 4'd1;
        end
    end

    always_ff @(posedge aclk) begin
`ifdef AXI_RAM_RESPONDER_WSTRB_EN
        for (int i = 0; i < AXI_DATA_WIDTH / 8; i++)
            if (w_fire && s_axi_wstrb[i]) mem[w_addr][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
`else
        if (w_fire) mem[w_addr] <= s_axi_wdata;
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        if (r_state == R_IDLE && ar_fire)                    r_next = R_DATA;
        else if (r_state == R_DATA && r_fire && s_axi_rlast) r_next = R_IDLE;
    end

    always_comb begin
        s_axi_arready = live && r_state == R_IDLE;
        s_axi_rvalid  = r_state == R_DATA;
    end

    // rdata is prefetched one word ahead; a same-cycle write to that word is seen on the next burst only
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr      <= '0;
            r_left      <= '0;
            s_axi_rid   <= '0;
            s_axi_rdata <= '0;
            s_axi_rlast <= 1'b0;
        end else if (ar_fire) begin
            r_addr      <= ar_idx + ADDR_WIDTH'(1);
            r_left      <= s_axi_arlen;
            s_axi_rid   <= s_axi_arid;
            s_axi_rdata <= mem[ar_idx];
            s_axi_rlast <= s_axi_arlen == 4'd0;
        end else if (r_fire && !s_axi_rlast) begin
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_left      <= r_left - 4'd1;
            s_axi_rdata <= mem[r_addr];
            s_axi_rlast <= r_left == 4'd1;
        end
    end
endmodule
